// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single 32-bit stb/ack SRAM controller.
// A granted request is latched and presented to the slave until it acks
// (or the watchdog expires); the ack and read data are returned only to
// the winner. Every transaction is followed by one idle cycle with stb low.
module sram_arbiter #(
    parameter bit FIXED_PRIO = 1'b0,   // 1: requester 0 wins every tie
    parameter int TIMEOUT    = 15      // BUSY cycles without ack before forced end (1..15)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    // requester 0 (CPU data port)
    input  logic [19:0] i_m0_addr,
    input  logic [3:0]  i_m0_we,
    input  logic [31:0] i_m0_dat_w,
    input  logic        i_m0_stb,
    output logic [31:0] o_m0_dat_r,
    output logic        o_m0_ack,
    // requester 1 (instruction fetch / DMA)
    input  logic [19:0] i_m1_addr,
    input  logic [3:0]  i_m1_we,
    input  logic [31:0] i_m1_dat_w,
    input  logic        i_m1_stb,
    output logic [31:0] o_m1_dat_r,
    output logic        o_m1_ack,
    // slave side
    output logic [19:0] o_addr,
    output logic [3:0]  o_we,
    output logic [31:0] o_dat_w,
    output logic        o_stb,
    input  logic [31:0] i_dat_r,
    input  logic        i_ack,
    // status
    output logic        o_busy,
    output logic        o_timeout
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Watchdog fires on the BUSY cycle where the counter reaches this value.
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic [19:0] addr_q, addr_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] dat_w_q, dat_w_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        timeout_q, timeout_d;

    // Requester inputs gathered into arrays so the winner can be selected by index.
    logic [19:0] req_addr  [2];
    logic [3:0]  req_we    [2];
    logic [31:0] req_dat_w [2];
    logic [1:0]  req_stb;
    logic [1:0]  ack_vec;
    logic [31:0] dat_r_arr [2];

    assign req_addr[0]  = i_m0_addr;
    assign req_addr[1]  = i_m1_addr;
    assign req_we[0]    = i_m0_we;
    assign req_we[1]    = i_m1_we;
    assign req_dat_w[0] = i_m0_dat_w;
    assign req_dat_w[1] = i_m1_dat_w;
    assign req_stb      = {i_m1_stb, i_m0_stb};

    logic winner;
    logic expiry;
    logic txn_done;

    // Winner selection: a lone requester wins; a tie goes to requester 0
    // under fixed priority, otherwise to whoever was not served last.
    always_comb begin
        winner = 1'b0;
        if (req_stb == 2'b11) begin
            winner = FIXED_PRIO ? 1'b0 : ~last_q;
        end else begin
            winner = req_stb[1];
        end
    end

    // Watchdog expiry only counts when the slave did not ack in the same cycle.
    assign expiry   = (state_q == ST_BUSY) && !i_ack && (cnt_q == CNT_LAST);
    assign txn_done = (state_q == ST_BUSY) && (i_ack || expiry);

    // Next-state logic: arbitrate and latch in IDLE, wait for ack or expiry in BUSY.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        addr_d    = addr_q;
        we_d      = we_q;
        dat_w_d   = dat_w_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                // A stray slave ack while idle falls through here untouched.
                if (req_stb != 2'b00) begin
                    addr_d  = req_addr[winner];
                    we_d    = req_we[winner];
                    dat_w_d = req_dat_w[winner];
                    grant_d = winner;
                    last_d  = winner;
                    cnt_d   = 4'd0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (i_ack) begin
                    state_d = ST_IDLE;
                end else if (expiry) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched-request registers; reset abandons any transaction silently.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            addr_q    <= '0;
            we_q      <= '0;
            dat_w_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            dat_w_q   <= dat_w_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Ack and read-data routing to the granted requester; a watchdog ack carries zero data.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_route
            assign ack_vec[gi]   = txn_done && (grant_q == 1'(gi));
            assign dat_r_arr[gi] = (ack_vec[gi] && i_ack) ? i_dat_r : 32'd0;
        end
    endgenerate

    assign o_m0_ack   = ack_vec[0];
    assign o_m1_ack   = ack_vec[1];
    assign o_m0_dat_r = dat_r_arr[0];
    assign o_m1_dat_r = dat_r_arr[1];

    assign o_stb     = (state_q == ST_BUSY);
    assign o_busy    = (state_q == ST_BUSY);
    assign o_addr    = addr_q;
    assign o_we      = we_q;
    assign o_dat_w   = dat_w_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a behavioural slave with programmable ack latency,
// an ack scoreboard, a table of single transactions and a few hand sequences
// (reset mid-transaction, contention in both priority modes, stray slave ack).
module tb_sram_arbiter;

    logic        i_clk;
    logic        i_rst;
    logic [19:0] i_m0_addr, i_m1_addr;
    logic [3:0]  i_m0_we, i_m1_we;
    logic [31:0] i_m0_dat_w, i_m1_dat_w;
    logic        i_m0_stb, i_m1_stb;
    logic [31:0] i_dat_r;
    logic        i_ack;

    // round-robin instance
    logic [31:0] o_m0_dat_r, o_m1_dat_r;
    logic        o_m0_ack, o_m1_ack;
    logic [19:0] o_addr;
    logic [3:0]  o_we;
    logic [31:0] o_dat_w;
    logic        o_stb, o_busy, o_timeout;

    // fixed-priority instance (shares all inputs, runs in lockstep)
    logic [31:0] fp_m0_dat_r, fp_m1_dat_r;
    logic        fp_m0_ack, fp_m1_ack;
    logic [19:0] fp_addr;
    logic [3:0]  fp_we;
    logic [31:0] fp_dat_w;
    logic        fp_stb, fp_busy, fp_timeout;

    sram_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT(15)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m0_addr(i_m0_addr), .i_m0_we(i_m0_we), .i_m0_dat_w(i_m0_dat_w), .i_m0_stb(i_m0_stb),
        .o_m0_dat_r(o_m0_dat_r), .o_m0_ack(o_m0_ack),
        .i_m1_addr(i_m1_addr), .i_m1_we(i_m1_we), .i_m1_dat_w(i_m1_dat_w), .i_m1_stb(i_m1_stb),
        .o_m1_dat_r(o_m1_dat_r), .o_m1_ack(o_m1_ack),
        .o_addr(o_addr), .o_we(o_we), .o_dat_w(o_dat_w), .o_stb(o_stb),
        .i_dat_r(i_dat_r), .i_ack(i_ack),
        .o_busy(o_busy), .o_timeout(o_timeout)
    );

    sram_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT(15)) dut_fp (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m0_addr(i_m0_addr), .i_m0_we(i_m0_we), .i_m0_dat_w(i_m0_dat_w), .i_m0_stb(i_m0_stb),
        .o_m0_dat_r(fp_m0_dat_r), .o_m0_ack(fp_m0_ack),
        .i_m1_addr(i_m1_addr), .i_m1_we(i_m1_we), .i_m1_dat_w(i_m1_dat_w), .i_m1_stb(i_m1_stb),
        .o_m1_dat_r(fp_m1_dat_r), .o_m1_ack(fp_m1_ack),
        .o_addr(fp_addr), .o_we(fp_we), .o_dat_w(fp_dat_w), .o_stb(fp_stb),
        .i_dat_r(i_dat_r), .i_ack(i_ack),
        .o_busy(fp_busy), .o_timeout(fp_timeout)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        int          who;
        logic [31:0] dat;
    } exp_t;

    typedef struct {
        logic        s0, s1;
        logic [19:0] a0, a1;
        logic [3:0]  w0, w1;
        logic [31:0] d0, d1;
        int          lat;       // slave ack latency in cycles after stb; 0 = never
        logic [31:0] sdat;
        int          exp_g;
        logic [19:0] exp_addr;
        logic [3:0]  exp_we;
        logic [31:0] exp_dw;
        logic [31:0] exp_rd;
    } vec_t;

    localparam logic [31:0] GARBAGE = 32'hA5A5_5A5A;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    int          slv_lat = 1;
    int          slv_cnt = 0;
    logic [31:0] slv_data = 32'h0;
    logic        slv_force = 1'b0;
    logic        prev_stb, prev_ack;
    logic        ack_now;
    int          fp_n0 = 0;
    int          fp_n1 = 0;
    logic        exp_to = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock: advance the slave model, then score any requester ack.
    task automatic tick();
        exp_t e;
        int   got_who;
        prev_stb = o_stb;
        prev_ack = i_ack;
        @(posedge i_clk);
        #1;
        if (prev_stb && !prev_ack) slv_cnt++;
        else                       slv_cnt = 0;
        i_ack   = ((slv_lat != 0) && (slv_cnt == slv_lat)) || slv_force;
        i_dat_r = i_ack ? slv_data : GARBAGE;
        #1;
        ack_now = o_m0_ack || o_m1_ack;
        if (fp_m0_ack) fp_n0++;
        if (fp_m1_ack) fp_n1++;
        if (ack_now) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: m0_ack=%0b m1_ack=%0b expected none (t=%0t)",
                         o_m0_ack, o_m1_ack, $time);
            end else begin
                e = sb_q.pop_front();
                got_who = (o_m0_ack && o_m1_ack) ? 2 : (o_m1_ack ? 1 : 0);
                chk("ack_owner", 32'(got_who), 32'(e.who));
                chk("ack_data", (got_who == 1) ? o_m1_dat_r : o_m0_dat_r, e.dat);
                chk("loser_data_zero", (got_who == 1) ? o_m0_dat_r : o_m1_dat_r, 32'd0);
            end
        end
    endtask

    task automatic drop_all();
        i_m0_stb = 1'b0;
        i_m1_stb = 1'b0;
    endtask

    // Run one isolated transaction from the table and check it end to end.
    task automatic run_vec(input vec_t v, input int idx);
        int nb;
        int exp_len;
        exp_t e;
        i_m0_addr = v.a0; i_m0_we = v.w0; i_m0_dat_w = v.d0; i_m0_stb = v.s0;
        i_m1_addr = v.a1; i_m1_we = v.w1; i_m1_dat_w = v.d1; i_m1_stb = v.s1;
        slv_lat  = v.lat;
        slv_data = v.sdat;
        e.who = v.exp_g;
        e.dat = v.exp_rd;
        sb_q.push_back(e);
        tick();
        chk($sformatf("v%0d_stb_up", idx), 32'(o_stb), 32'd1);
        chk($sformatf("v%0d_busy_up", idx), 32'(o_busy), 32'd1);
        chk($sformatf("v%0d_addr", idx), 32'(o_addr), 32'(v.exp_addr));
        chk($sformatf("v%0d_we", idx), 32'(o_we), 32'(v.exp_we));
        chk($sformatf("v%0d_dat_w", idx), o_dat_w, v.exp_dw);
        // Requesters change their payload after the grant; the slave side must not.
        i_m0_addr = ~v.a0; i_m0_we = ~v.w0; i_m0_dat_w = ~v.d0;
        i_m1_addr = ~v.a1; i_m1_we = ~v.w1; i_m1_dat_w = ~v.d1;
        nb = 1;
        while (!ack_now && nb < 20) begin
            tick();
            nb++;
            chk($sformatf("v%0d_addr_hold", idx), 32'(o_addr), 32'(v.exp_addr));
            chk($sformatf("v%0d_dat_w_hold", idx), o_dat_w, v.exp_dw);
            chk($sformatf("v%0d_stb_hold", idx), 32'(o_stb), 32'd1);
            if (!ack_now) begin
                chk($sformatf("v%0d_m0_dat_idle", idx), o_m0_dat_r, 32'd0);
                chk($sformatf("v%0d_m1_dat_idle", idx), o_m1_dat_r, 32'd0);
            end
        end
        exp_len = (v.lat == 0) ? 15 : v.lat + 1;
        chk($sformatf("v%0d_busy_cycles", idx), 32'(nb), 32'(exp_len));
        if (v.lat == 0) exp_to = 1'b1;
        tick();
        drop_all();
        chk($sformatf("v%0d_gap_stb", idx), 32'(o_stb), 32'd0);
        chk($sformatf("v%0d_gap_busy", idx), 32'(o_busy), 32'd0);
        chk($sformatf("v%0d_timeout_flag", idx), 32'(o_timeout), 32'(exp_to));
        tick();
    endtask

    vec_t vecs[7];
    exp_t e;

    initial begin
        // Table: {s0,s1,a0,a1,w0,w1,d0,d1,lat,sdat,exp_g,exp_addr,exp_we,exp_dw,exp_rd}
        vecs[0] = '{1'b1, 1'b0, 20'h00010, 20'h00000, 4'h0, 4'h0, 32'h0, 32'h0,
                    1, 32'hDEADBEEF, 0, 20'h00010, 4'h0, 32'h0, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 1'b1, 20'h00000, 20'h0ABCD, 4'h0, 4'b0011, 32'h0, 32'h12345678,
                    3, 32'h55AA55AA, 1, 20'h0ABCD, 4'b0011, 32'h12345678, 32'h55AA55AA};
        vecs[2] = '{1'b1, 1'b1, 20'h11111, 20'h22222, 4'h0, 4'hF, 32'h0, 32'hCAFEF00D,
                    1, 32'h01020304, 0, 20'h11111, 4'h0, 32'h0, 32'h01020304};
        vecs[3] = '{1'b1, 1'b1, 20'h33333, 20'h44444, 4'h1, 4'h2, 32'h0BADF00D, 32'hFEEDFACE,
                    2, 32'h99887766, 1, 20'h44444, 4'h2, 32'hFEEDFACE, 32'h99887766};
        vecs[4] = '{1'b0, 1'b1, 20'h00000, 20'hFFFFF, 4'h0, 4'h0, 32'h0, 32'h0,
                    0, 32'h13579BDF, 1, 20'hFFFFF, 4'h0, 32'h0, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 20'h5A5A5, 20'hA5A5A, 4'h0, 4'h0, 32'h0, 32'h0,
                    3, 32'h2468ACE0, 0, 20'h5A5A5, 4'h0, 32'h0, 32'h2468ACE0};
        vecs[6] = '{1'b1, 1'b0, 20'h00001, 20'h00000, 4'hF, 4'h0, 32'hFFFFFFFF, 32'h0,
                    1, 32'h76543210, 0, 20'h00001, 4'hF, 32'hFFFFFFFF, 32'h76543210};

        i_rst = 1'b1;
        i_m0_addr = '0; i_m0_we = '0; i_m0_dat_w = '0; i_m0_stb = 1'b0;
        i_m1_addr = '0; i_m1_we = '0; i_m1_dat_w = '0; i_m1_stb = 1'b0;
        i_ack = 1'b0;
        i_dat_r = GARBAGE;
        ack_now = 1'b0;
        tick();
        tick();
        chk("rst_stb", 32'(o_stb), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        chk("rst_addr", 32'(o_addr), 32'd0);
        chk("rst_we", 32'(o_we), 32'd0);
        chk("rst_dat_w", o_dat_w, 32'd0);
        chk("rst_acks", 32'({o_m1_ack, o_m0_ack}), 32'd0);
        i_rst = 1'b0;
        tick();

        // Table-driven single transactions.
        for (int k = 0; k < 7; k++) begin
            run_vec(vecs[k], k);
        end

        // A slave ack while idle must be ignored.
        slv_force = 1'b1;
        tick();
        chk("idle_ack_m0", 32'(o_m0_ack), 32'd0);
        chk("idle_ack_m1", 32'(o_m1_ack), 32'd0);
        slv_force = 1'b0;
        tick();
        chk("idle_ack_no_busy", 32'(o_busy), 32'd0);

        // Reset in the middle of a hung transaction: no ack, everything cleared.
        i_m0_addr = 20'h00777; i_m0_we = 4'h0; i_m0_stb = 1'b1;
        slv_lat = 0;
        tick();
        tick();
        chk("pre_rst_busy", 32'(o_busy), 32'd1);
        i_rst = 1'b1;
        tick();
        exp_to = 1'b0;
        chk("midrst_stb", 32'(o_stb), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_timeout", 32'(o_timeout), 32'd0);
        chk("midrst_addr", 32'(o_addr), 32'd0);
        chk("midrst_ack", 32'({o_m1_ack, o_m0_ack}), 32'd0);
        drop_all();
        i_rst = 1'b0;
        tick();
        chk("postrst_busy", 32'(o_busy), 32'd0);

        // Continuous contention: round-robin grants 0,1,0,1; fixed priority grants only m0.
        slv_lat  = 1;
        slv_data = 32'hC0DE0001;
        fp_n0 = 0;
        fp_n1 = 0;
        for (int k = 0; k < 4; k++) begin
            e.who = k % 2;
            e.dat = 32'hC0DE0001;
            sb_q.push_back(e);
        end
        i_m0_addr = 20'h0000A; i_m0_we = 4'h0; i_m0_stb = 1'b1;
        i_m1_addr = 20'h0000B; i_m1_we = 4'h0; i_m1_stb = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("rr_stb_c%0d", k), 32'(o_stb), (k % 3 != 0) ? 32'd1 : 32'd0);
        end
        chk("fp_m0_grants", 32'(fp_n0), 32'd4);
        chk("fp_m1_grants", 32'(fp_n1), 32'd0);
        // Drop m0 in the gap cycle: both instances must now serve m1.
        i_m0_stb = 1'b0;
        e.who = 1;
        e.dat = 32'hC0DE0001;
        sb_q.push_back(e);
        tick();
        chk("after_drop_addr", 32'(o_addr), 32'h0000B);
        chk("fp_after_drop_addr", 32'(fp_addr), 32'h0000B);
        tick();
        chk("after_drop_ack", 32'(ack_now), 32'd1);
        chk("fp_m1_after_drop", 32'(fp_n1), 32'd1);
        chk("fp_m0_after_drop", 32'(fp_n0), 32'd4);
        tick();
        drop_all();
        chk("final_gap_stb", 32'(o_stb), 32'd0);
        tick();
        tick();

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL time_limit: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
